// File: rtl/apb_ram_pkg.sv
// Shared types and helpers for the APB4 wait-state RAM slave.
// Widths here cover the largest supported data bus (64 bits).
package apb_ram_pkg;

  localparam int APB_PROT_WIDTH = 3;
  localparam int MAX_DATA_WIDTH = 64;
  localparam int MAX_STRB_WIDTH = MAX_DATA_WIDTH / 8;
  localparam int WAIT_CNT_WIDTH = 4;
  localparam int ERR_CNT_WIDTH  = 8;
  localparam int ERR_CAUSES     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Each cause owns one bit of the error vector so coverage can see them apart.
  typedef enum logic [1:0] {
    RANGE = 2'd0,
    ALIGN = 2'd1,
    STRB  = 2'd2,
    PRIV  = 2'd3
  } err_cause_t;

  // Expands byte strobes to a bit mask; callers zero-pad strobes and slice the result.
  function automatic logic [MAX_DATA_WIDTH-1:0] strb_mask(
    input logic [MAX_STRB_WIDTH-1:0] strb
  );
    logic [MAX_DATA_WIDTH-1:0] mask;
    mask = '0;
    for (int i = 0; i < MAX_STRB_WIDTH; i++) begin
      mask[i*8 +: 8] = {8{strb[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/apb_ram_bytemem.sv
// Word array with synchronous byte-lane write and combinational read, so the
// owner can register read data on the same edge that it commits a write.
module apb_ram_bytemem
  import apb_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256,
  parameter int IDX_W      = 8
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [IDX_W-1:0]        waddr,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [IDX_W-1:0]        raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0]     mem_q [MEM_DEPTH];
  logic [MAX_STRB_WIDTH-1:0] be_full;
  logic [MAX_DATA_WIDTH-1:0] mask_full;
  logic [DATA_WIDTH-1:0]     mask;
  logic [DATA_WIDTH-1:0]     merged_d;

  always_comb begin
    be_full         = '0;
    be_full[NB-1:0] = be;
    mask_full       = strb_mask(be_full);
    mask            = mask_full[DATA_WIDTH-1:0];
    // Lanes without a strobe keep the old word contents.
    merged_d        = (mem_q[waddr] & ~mask) | (wdata & mask);
  end

  if (DATA_WIDTH < MAX_DATA_WIDTH) begin : g_mask_pad
    logic unused_mask_hi;
    assign unused_mask_hi = ^mask_full[MAX_DATA_WIDTH-1:DATA_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= merged_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/apb_ram_slave_ws.sv
// APB4 RAM slave with programmable wait states, byte-lane writes, range/alignment/
// strobe/privilege checks and a saturating error counter; all outputs registered.
// Handshake: a transfer is a setup cycle (PSEL & ~PENABLE) followed by access cycles
// (PSEL & PENABLE) held until PREADY=1; PRDATA/PSLVERR are only meaningful with PREADY=1.
module apb_ram_slave_ws
  import apb_ram_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0,
  parameter int PRIV_ONLY   = 0
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  input  logic                      PWRITE,
  input  logic [ADDR_WIDTH-1:0]     PADDR,
  input  logic [DATA_WIDTH-1:0]     PWDATA,
  input  logic [DATA_WIDTH/8-1:0]   PSTRB,
  input  logic [APB_PROT_WIDTH-1:0] PPROT,
  output logic [DATA_WIDTH-1:0]     PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic [ERR_CNT_WIDTH-1:0]  ERR_CNT,
  output state_t                    dbg_state
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFS    = $clog2(STRB_W);
  localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK  = ADDR_WIDTH'((1 << OFS) - 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_LIMIT = ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [WAIT_CNT_WIDTH-1:0] CNT_INIT = WAIT_CNT_WIDTH'(WAIT_STATES - 1);

  state_t                      state_q, state_d;
  logic [WAIT_CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
  logic                        write_q, write_d;
  logic [DATA_WIDTH-1:0]       wdata_q, wdata_d;
  logic [STRB_W-1:0]           strb_q, strb_d;
  logic [APB_PROT_WIDTH-1:0]   prot_q, prot_d;
  logic [DATA_WIDTH-1:0]       prdata_q, prdata_d;
  logic                        pready_q, pready_d;
  logic                        pslverr_q, pslverr_d;
  logic [ERR_CNT_WIDTH-1:0]    err_cnt_q, err_cnt_d;

  logic                        setup;
  logic [ADDR_WIDTH-1:0]       cur_addr;
  logic                        cur_write;
  logic [DATA_WIDTH-1:0]       cur_wdata;
  logic [STRB_W-1:0]           cur_strb;
  logic                        cur_priv;
  logic [ADDR_WIDTH-1:0]       idx_full;
  logic [ERR_CAUSES-1:0]       err_vec;
  logic                        err;
  logic                        commit;
  logic                        mem_we;
  logic [DATA_WIDTH-1:0]       mem_rdata;
  logic                        unused_prot;

  assign setup = PSEL && !PENABLE;

  // With zero wait states the commit edge is the setup edge, so use the live bus.
  always_comb begin
    if (state_q == IDLE) begin
      cur_addr  = PADDR;
      cur_write = PWRITE;
      cur_wdata = PWDATA;
      cur_strb  = PSTRB;
      cur_priv  = PPROT[0];
    end else begin
      cur_addr  = addr_q;
      cur_write = write_q;
      cur_wdata = wdata_q;
      cur_strb  = strb_q;
      cur_priv  = prot_q[0];
    end
  end

  assign unused_prot = ^{PPROT[APB_PROT_WIDTH-1:1], prot_q[APB_PROT_WIDTH-1:1]};

  // State register and captured transfer.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      prot_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      prot_q  <= prot_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    prot_d  = prot_q;
    unique case (state_q)
      IDLE: begin
        if (setup) begin
          addr_d  = PADDR;
          write_d = PWRITE;
          wdata_d = PWDATA;
          strb_d  = PSTRB;
          prot_d  = PPROT;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (!PSEL) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign idx_full = cur_addr >> OFS;

  always_comb begin
    err_vec        = '0;
    err_vec[RANGE] = idx_full >= DEPTH_LIMIT;
    err_vec[ALIGN] = (cur_addr & ALIGN_MASK) != '0;
    err_vec[STRB]  = !cur_write && (cur_strb != '0);
    err_vec[PRIV]  = (PRIV_ONLY != 0) && !cur_priv;
    err            = |err_vec;
  end

  // Output logic: everything is decided on the edge that enters RESP.
  always_comb begin
    commit    = (state_d == RESP) && !PRESET;
    mem_we    = commit && cur_write && !err;
    pready_d  = commit;
    pslverr_d = commit && err;
    prdata_d  = prdata_q;
    err_cnt_d = err_cnt_q;
    if (commit && !cur_write && !err) begin
      prdata_d = mem_rdata;
    end
    if (commit && err && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  apb_ram_bytemem #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .IDX_W      (IDX_W)
  ) u_mem (
    .clk   (PCLK),
    .we    (mem_we),
    .waddr (idx_full[IDX_W-1:0]),
    .be    (cur_strb),
    .wdata (cur_wdata),
    .raddr (idx_full[IDX_W-1:0]),
    .rdata (mem_rdata)
  );

  assign PRDATA    = prdata_q;
  assign PREADY    = pready_q;
  assign PSLVERR   = pslverr_q;
  assign ERR_CNT   = err_cnt_q;
  assign dbg_state = state_q;

  assert property (@(posedge PCLK) disable iff (PRESET)
    (PSEL && !PENABLE) |-> !$isunknown({PADDR, PWRITE}));

endmodule

// File: tb/tb_apb_ram_slave_ws.sv
// Directed bench for apb_ram_slave_ws: three instances (0, 3 and 4 wait states,
// the last privileged-only) share the bus data lines and have their own PSEL/PRESET.
module tb_apb_ram_slave_ws;
  import apb_ram_pkg::*;

  logic        pclk;
  logic        preset [3];
  logic        psel   [3];
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] prdata_o  [3];
  logic        pready_o  [3];
  logic        pslverr_o [3];
  logic [7:0]  err_cnt_o [3];
  state_t      dbg_o     [3];

  int checks = 0;
  int errors = 0;

  // Clock / reset
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  apb_ram_slave_ws #(.WAIT_STATES(0), .PRIV_ONLY(0)) dut_w0 (
    .PCLK(pclk), .PRESET(preset[0]), .PSEL(psel[0]), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
    .PRDATA(prdata_o[0]), .PREADY(pready_o[0]), .PSLVERR(pslverr_o[0]),
    .ERR_CNT(err_cnt_o[0]), .dbg_state(dbg_o[0])
  );

  apb_ram_slave_ws #(.WAIT_STATES(3), .PRIV_ONLY(0)) dut_w3 (
    .PCLK(pclk), .PRESET(preset[1]), .PSEL(psel[1]), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
    .PRDATA(prdata_o[1]), .PREADY(pready_o[1]), .PSLVERR(pslverr_o[1]),
    .ERR_CNT(err_cnt_o[1]), .dbg_state(dbg_o[1])
  );

  apb_ram_slave_ws #(.WAIT_STATES(4), .PRIV_ONLY(1)) dut_w4p (
    .PCLK(pclk), .PRESET(preset[2]), .PSEL(psel[2]), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
    .PRDATA(prdata_o[2]), .PREADY(pready_o[2]), .PSLVERR(pslverr_o[2]),
    .ERR_CNT(err_cnt_o[2]), .dbg_state(dbg_o[2])
  );

  // Driver tasks: drive on the falling edge, sample registered outputs there too.
  task automatic apb_xfer(input int d, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          input logic [2:0] prot, output logic [31:0] rdata,
                          output logic err, output int waits);
    @(negedge pclk);
    psel[d] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wdata;
    pstrb   = strb;
    pprot   = prot;
    @(negedge pclk);
    penable = 1'b1;
    waits   = 0;
    while (pready_o[d] !== 1'b1 && waits < 40) begin
      @(negedge pclk);
      waits++;
    end
    if (pready_o[d] !== 1'b1) waits = -1;
    rdata = prdata_o[d];
    err   = pslverr_o[d];
  endtask

  task automatic bus_idle(input int d);
    @(negedge pclk);
    psel[d] = 1'b0;
    penable = 1'b0;
    pstrb   = 4'h0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      preset[i] = 1'b1;
      psel[i]   = 1'b0;
    end
    penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
    repeat (3) @(negedge pclk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (prdata_o[i] !== 32'h0) begin
        errors++; $display("FAIL reset_prdata[%0d]: got %h want 00000000", i, prdata_o[i]);
      end
      checks++;
      if (pready_o[i] !== 1'b0) begin
        errors++; $display("FAIL reset_pready[%0d]: got %b want 0", i, pready_o[i]);
      end
      checks++;
      if (pslverr_o[i] !== 1'b0) begin
        errors++; $display("FAIL reset_pslverr[%0d]: got %b want 0", i, pslverr_o[i]);
      end
      checks++;
      if (err_cnt_o[i] !== 8'd0) begin
        errors++; $display("FAIL reset_err_cnt[%0d]: got %0d want 0", i, err_cnt_o[i]);
      end
      checks++;
      if (dbg_o[i] !== IDLE) begin
        errors++; $display("FAIL reset_state[%0d]: got %0d want IDLE", i, dbg_o[i]);
      end
    end
    for (int i = 0; i < 3; i++) preset[i] = 1'b0;
  endtask

  task automatic test_basic_w0();
    logic [31:0] rd; logic er; int w;
    apb_xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, rd, er, w);
    checks++;
    if (w !== 0 || er !== 1'b0) begin
      errors++; $display("FAIL w0_write: waits %0d err %b want waits 0 err 0", w, er);
    end
    apb_xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000, rd, er, w);
    checks++;
    if (w !== 0) begin
      errors++; $display("FAIL w0_read_latency: waits %0d want 0", w);
    end
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      errors++; $display("FAIL w0_read_data: got %h err %b want DEADBEEF err 0", rd, er);
    end
    bus_idle(0);
    checks++;
    if (pready_o[0] !== 1'b0 || pslverr_o[0] !== 1'b0 || prdata_o[0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL w0_after_resp: pready %b pslverr %b prdata %h want 0 0 DEADBEEF",
               pready_o[0], pslverr_o[0], prdata_o[0]);
    end
  endtask

  task automatic test_merge_w3();
    logic [31:0] rd; logic er; int w;
    apb_xfer(1, 1'b1, 32'h04, 32'hAABBCCDD, 4'hF, 3'b000, rd, er, w);
    checks++;
    if (w !== 3 || er !== 1'b0) begin
      errors++; $display("FAIL w3_write_full: waits %0d err %b want waits 3 err 0", w, er);
    end
    apb_xfer(1, 1'b1, 32'h04, 32'h11223344, 4'b0101, 3'b000, rd, er, w);
    checks++;
    if (er !== 1'b0) begin
      errors++; $display("FAIL w3_write_partial: err %b want 0", er);
    end
    apb_xfer(1, 1'b0, 32'h04, 32'h0, 4'h0, 3'b000, rd, er, w);
    checks++;
    if (w !== 3) begin
      errors++; $display("FAIL w3_read_latency: waits %0d want 3", w);
    end
    checks++;
    if (rd !== 32'hAA22CC44 || er !== 1'b0) begin
      errors++; $display("FAIL w3_merge: got %h err %b want AA22CC44 err 0", rd, er);
    end
    apb_xfer(1, 1'b1, 32'h04, 32'hFFFFFFFF, 4'h0, 3'b000, rd, er, w);
    checks++;
    if (er !== 1'b0) begin
      errors++; $display("FAIL w3_zero_strb_err: err %b want 0", er);
    end
    apb_xfer(1, 1'b0, 32'h04, 32'h0, 4'h0, 3'b000, rd, er, w);
    checks++;
    if (rd !== 32'hAA22CC44) begin
      errors++; $display("FAIL w3_zero_strb_data: got %h want AA22CC44", rd);
    end
    bus_idle(1);
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int w;
    apb_xfer(0, 1'b1, 32'h00, 32'h0BADF00D, 4'hF, 3'b000, rd, er, w);
    apb_xfer(0, 1'b0, 32'h400, 32'h0, 4'h0, 3'b000, rd, er, w);
    checks++;
    if (er !== 1'b1 || err_cnt_o[0] !== 8'd1) begin
      errors++; $display("FAIL err_range: err %b cnt %0d want 1 1", er, err_cnt_o[0]);
    end
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL err_range_prdata_held: got %h want DEADBEEF", rd);
    end
    apb_xfer(0, 1'b1, 32'h02, 32'h12345678, 4'hF, 3'b000, rd, er, w);
    checks++;
    if (er !== 1'b1) begin
      errors++; $display("FAIL err_align: err %b want 1", er);
    end
    apb_xfer(0, 1'b0, 32'h00, 32'h0, 4'h0, 3'b000, rd, er, w);
    checks++;
    if (rd !== 32'h0BADF00D || er !== 1'b0) begin
      errors++; $display("FAIL err_align_mem: got %h err %b want 0BADF00D 0", rd, er);
    end
    apb_xfer(0, 1'b0, 32'h10, 32'h0, 4'b0001, 3'b000, rd, er, w);
    checks++;
    if (er !== 1'b1 || err_cnt_o[0] !== 8'd3) begin
      errors++; $display("FAIL err_strb: err %b cnt %0d want 1 3", er, err_cnt_o[0]);
    end
    checks++;
    if (rd !== 32'h0BADF00D) begin
      errors++; $display("FAIL err_strb_prdata_held: got %h want 0BADF00D", rd);
    end
    apb_xfer(0, 1'b1, 32'h3FC, 32'hCAFEF00D, 4'hF, 3'b000, rd, er, w);
    apb_xfer(0, 1'b0, 32'h3FC, 32'h0, 4'h0, 3'b000, rd, er, w);
    checks++;
    if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
      errors++; $display("FAIL last_word: got %h err %b want CAFEF00D 0", rd, er);
    end
    bus_idle(0);
  endtask

  task automatic test_priv();
    logic [31:0] rd; logic er; int w;
    apb_xfer(2, 1'b1, 32'h20, 32'h01020304, 4'hF, 3'b001, rd, er, w);
    checks++;
    if (w !== 4 || er !== 1'b0) begin
      errors++; $display("FAIL priv_setup_write: waits %0d err %b want 4 0", w, er);
    end
    apb_xfer(2, 1'b1, 32'h20, 32'hA5A5A5A5, 4'hF, 3'b000, rd, er, w);
    checks++;
    if (er !== 1'b1 || err_cnt_o[2] !== 8'd1) begin
      errors++; $display("FAIL priv_refuse: err %b cnt %0d want 1 1", er, err_cnt_o[2]);
    end
    apb_xfer(2, 1'b0, 32'h20, 32'h0, 4'h0, 3'b001, rd, er, w);
    checks++;
    if (rd !== 32'h01020304) begin
      errors++; $display("FAIL priv_no_update: got %h want 01020304", rd);
    end
    apb_xfer(2, 1'b1, 32'h20, 32'hA5A5A5A5, 4'hF, 3'b001, rd, er, w);
    checks++;
    if (er !== 1'b0) begin
      errors++; $display("FAIL priv_accept: err %b want 0", er);
    end
    apb_xfer(2, 1'b0, 32'h20, 32'h0, 4'h0, 3'b001, rd, er, w);
    checks++;
    if (rd !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL priv_update: got %h want A5A5A5A5", rd);
    end
    bus_idle(2);
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic er; int w; logic seen;
    @(negedge pclk);
    psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20;
    pwdata = 32'hFFFF0000; pstrb = 4'hF; pprot = 3'b001;
    @(negedge pclk);
    penable = 1'b1;
    checks++;
    if (pready_o[2] !== 1'b0) begin
      errors++; $display("FAIL abort_cycle1: pready %b want 0", pready_o[2]);
    end
    @(negedge pclk);
    psel[2] = 1'b0; penable = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge pclk);
      if (pready_o[2] !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || dbg_o[2] !== IDLE) begin
      errors++; $display("FAIL abort_no_resp: pready_seen %b state %0d want 0 IDLE", seen, dbg_o[2]);
    end
    apb_xfer(2, 1'b0, 32'h20, 32'h0, 4'h0, 3'b001, rd, er, w);
    checks++;
    if (rd !== 32'hA5A5A5A5 || w !== 4) begin
      errors++; $display("FAIL abort_no_write: got %h waits %0d want A5A5A5A5 4", rd, w);
    end
    bus_idle(2);
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd; logic er; int w;
    @(negedge pclk);
    psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20;
    pwdata = 32'h00000000; pstrb = 4'hF; pprot = 3'b001;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    preset[2] = 1'b1;
    @(negedge pclk);
    checks++;
    if (pready_o[2] !== 1'b0 || pslverr_o[2] !== 1'b0 || prdata_o[2] !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_outputs: pready %b pslverr %b prdata %h want 0 0 00000000",
               pready_o[2], pslverr_o[2], prdata_o[2]);
    end
    checks++;
    if (err_cnt_o[2] !== 8'd0 || dbg_o[2] !== IDLE) begin
      errors++; $display("FAIL rst_mid_state: cnt %0d state %0d want 0 IDLE", err_cnt_o[2], dbg_o[2]);
    end
    preset[2] = 1'b0; psel[2] = 1'b0; penable = 1'b0;
    apb_xfer(2, 1'b0, 32'h20, 32'h0, 4'h0, 3'b001, rd, er, w);
    checks++;
    if (rd !== 32'hA5A5A5A5 || er !== 1'b0) begin
      errors++; $display("FAIL rst_mid_data: got %h err %b want A5A5A5A5 0", rd, er);
    end
    bus_idle(2);
  endtask

  task automatic test_saturation();
    logic [31:0] rd; logic er; int w;
    for (int i = 0; i < 300; i++) begin
      apb_xfer(0, 1'b0, 32'h400, 32'h0, 4'h0, 3'b000, rd, er, w);
      if (i == 248) begin
        checks++;
        if (err_cnt_o[0] !== 8'd252) begin
          errors++; $display("FAIL sat_mid: cnt %0d want 252", err_cnt_o[0]);
        end
      end
    end
    checks++;
    if (err_cnt_o[0] !== 8'd255 || er !== 1'b1) begin
      errors++; $display("FAIL sat_end: cnt %0d err %b want 255 1", err_cnt_o[0], er);
    end
    bus_idle(0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int w;
    apb_xfer(0, 1'b1, 32'h44, 32'h13579BDF, 4'hF, 3'b000, rd, er, w);
    checks++;
    if (er !== 1'b0 || w !== 0) begin
      errors++; $display("FAIL b2b_write: err %b waits %0d want 0 0", er, w);
    end
    apb_xfer(0, 1'b0, 32'h44, 32'h0, 4'h0, 3'b000, rd, er, w);
    checks++;
    if (rd !== 32'h13579BDF || er !== 1'b0 || w !== 0) begin
      errors++; $display("FAIL b2b_read: got %h err %b waits %0d want 13579BDF 0 0", rd, er, w);
    end
    bus_idle(0);
  endtask

  initial begin
    test_reset();
    test_basic_w0();
    test_merge_w3();
    test_errors();
    test_priv();
    test_abort();
    test_reset_mid_wait();
    test_back_to_back();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
